car_sensor_gen: RTL and testbench
=================================

Name: car_sensor_gen

Overview:
- Generates the two-sensor vehicle-passage waveform (a, b) that the parking-meter counter consumes.
- The meter decodes a/b sequences into enter/exit events; this block produces those sequences on command.
- Used for on-board self-test and bench stimulus; drives the meter's a/b inputs directly, with no external sensors.
- Fully synchronous outputs, one clock domain.

Parameters:
- DWELL_W, 16, width of the per-phase hold-time input (cycles).
- CNT_W, 8, width of the completed-passage counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a passage; sampled only in IDLE.
- dir  in  1  0 = enter, 1 = exit; captured with start.
- dwell  in  DWELL_W  cycles each blocked phase is held; captured with start.
- a  out  1  sensor A level (1 = blocked), registered.
- b  out  1  sensor B level (1 = blocked), registered.
- busy  out  1  high while a passage is in progress.
- done  out  1  one-cycle pulse on passage completion.
- pass_cnt  out  CNT_W  completed passages since reset.

Behaviour:
- Reset (async, any time, including mid-passage): state=IDLE, a=0, b=0, busy=0, done=0, pass_cnt=0, internal counters=0. Interrupted passages are not counted.
- Hold length N = dwell if dwell != 0, else 1. It is latched at acceptance; later changes to dwell or dir have no effect.
- States: IDLE, P1, P2, P3.
- Phase patterns (a,b):
  - enter: P1=10, P2=11, P3=01.
  - exit: P1=01, P2=11, P3=10.
  - IDLE=00.
- Acceptance: start=1 at a rising edge while in IDLE. After that edge: state=P1, busy=1, a/b = P1 pattern.
- Each Pk lasts exactly N cycles, then advances P1→P2→P3→IDLE.
- On the P3→IDLE edge: a=b=0, busy=0, done=1 for exactly one cycle, and pass_cnt increments.
- Latency: done is asserted 3N edges after the acceptance edge.
- pass_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- start while busy=1 is ignored; there is no queueing.
- start in the done cycle is accepted, because the state is IDLE. Back-to-back passages are separated by exactly one 00 cycle.
- a and b never both change on the same edge, except that the reset assertion may force both low.

Optional Feature:
- Macro CAR_SENSOR_GEN_BOUNCE_EN.
- Defined:
  - Applies when N>=4. On entry to each phase, and on the return to IDLE, the one sensor that changes shows new/old/new over its first three cycles (a glitch on cycle 2). It then holds the new value.
  - For the IDLE return, the glitch cycles occur before done. done is delayed by 2 cycles: latency = 3N+2.
  - With N<4 there is no bounce.
- Undefined: clean transitions only; latency 3N.

Decomposition:
- Package car_gen_pkg holds:
  - State enum (IDLE, P1, P2, P3).
  - Pattern constants ENTER_P1..P3 and EXIT_P1..P3 as 2-bit a/b values.
  - DIR_ENTER=0 and DIR_EXIT=1.
  - Bounce glitch length constant (3).
- One sub-module, car_phase_timer:
  - Loadable down-counter of width DWELL_W.
  - Asserts expire on the last cycle of the phase.
  - Reloaded by the FSM on each phase entry.

Test Plan:
- Reset, then start=1, dir=0, dwell=2 at edge 0:
  - Edges 0–1: ab=10. Edges 2–3: ab=11. Edges 4–5: ab=01.
  - Edge 6: ab=00, done=1, busy=0, pass_cnt=1.
- dir=1, dwell=0 (N=1):
  - ab sequence 01, 11, 10, 00 on consecutive cycles.
  - done is 3 edges after acceptance.
- start pulsed again at edges 1 and 3 during a dwell=3 passage: ignored. Exactly one done, pass_cnt +1.
- start held high continuously with dwell=1, run 256 passages:
  - Each passage is 3 blocked cycles plus one 00 cycle.
  - pass_cnt wraps 255→0.
  - Check that ab never has both bits changing on the same edge.
- reset asserted asynchronously mid-P2 (ab=11), dwell=5: ab=00, busy=0, done=0, pass_cnt=0 immediately, without waiting for a clock edge. The next start runs a normal passage.
- BOUNCE_EN defined, dir=0, dwell=4:
  - P1: a = 1,0,1,1.
  - P2: b = 1,0,1,1.
  - P3: a = 0,1,0,0.
  - Return: b = 0,1,0, then done at edge 14.

Source files
------------

// File: rtl/car_gen_pkg.sv
// Shared types, a/b phase patterns and helpers for the car sensor waveform generator.
// Pattern bit order is {a, b}, with 1 meaning the sensor is blocked.
package car_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } state_t;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam logic [1:0] ENTER_P1 = 2'b10;
  localparam logic [1:0] ENTER_P2 = 2'b11;
  localparam logic [1:0] ENTER_P3 = 2'b01;
  localparam logic [1:0] EXIT_P1  = 2'b01;
  localparam logic [1:0] EXIT_P2  = 2'b11;
  localparam logic [1:0] EXIT_P3  = 2'b10;

  // A bounce shows new/old/new, so it spans three cycles of a phase.
  localparam int BOUNCE_LEN   = 3;
  localparam int BOUNCE_MIN_N = 4;

  function automatic logic [1:0] phase_pat(input state_t s, input logic dir);
    logic [1:0] pat;
    case (s)
      P1:      pat = (dir == DIR_EXIT) ? EXIT_P1 : ENTER_P1;
      P2:      pat = (dir == DIR_EXIT) ? EXIT_P2 : ENTER_P2;
      P3:      pat = (dir == DIR_EXIT) ? EXIT_P3 : ENTER_P3;
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

  function automatic state_t prev_state(input state_t s);
    state_t p;
    case (s)
      P2:      p = P1;
      P3:      p = P2;
      default: p = IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/car_sensor_gen_if.sv
// Command and waveform bundle of the car sensor generator.
// master drives the passage request, slave produces the a/b waveform and status.
interface car_sensor_gen_if #(
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
);
  logic               start;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               a;
  logic               b;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   pass_cnt;

  modport master (
    output start, dir, dwell,
    input  a, b, busy, done, pass_cnt
  );

  modport slave (
    input  start, dir, dwell,
    output a, b, busy, done, pass_cnt
  );
endinterface

// File: rtl/car_phase_timer.sv
// Loadable down-counter timing one phase; expire is high on the last cycle of the phase.
// Loading N-1 on phase entry gives a phase of exactly N cycles.
module car_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/car_sensor_gen.sv
// Two-sensor passage waveform generator; done follows acceptance by 3N edges (3N+2 with bounce).
// start is ignored while busy; CAR_SENSOR_GEN_BOUNCE_EN adds a one-cycle glitch on each edge when N>=4.
module car_sensor_gen
  import car_gen_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             reset,
  car_sensor_gen_if.slave bus
);

`ifdef CAR_SENSOR_GEN_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  logic               tail_q, tail_d;
  logic               first_q, first_d;
  logic               bounce_q, bounce_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] n_q, n_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DWELL_W-1:0] n_acc;
  logic               bounce_acc;
  logic               load;
  logic [DWELL_W-1:0] load_val;
  logic               expire;
  logic               finish;

  assign n_acc      = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign bounce_acc = BOUNCE_EN && (n_acc >= DWELL_W'(BOUNCE_MIN_N));

  car_phase_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tail_q   <= 1'b0;
      first_q  <= 1'b0;
      bounce_q <= 1'b0;
      dir_q    <= 1'b0;
      n_q      <= '0;
      ab_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tail_q   <= tail_d;
      first_q  <= first_d;
      bounce_q <= bounce_d;
      dir_q    <= dir_d;
      n_q      <= n_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // The bounced return to IDLE is a two-cycle tail kept inside P3 so done lands 2 edges later.
  always_comb begin
    state_d  = state_q;
    tail_d   = tail_q;
    dir_d    = dir_q;
    n_d      = n_q;
    bounce_d = bounce_q;
    load     = 1'b0;
    load_val = n_q - DWELL_W'(1);
    first_d  = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = P1;
          dir_d    = bus.dir;
          n_d      = n_acc;
          bounce_d = bounce_acc;
          load     = 1'b1;
          load_val = n_acc - DWELL_W'(1);
          first_d  = 1'b1;
        end
      end
      P1: begin
        if (expire) begin
          state_d = P2;
          load    = 1'b1;
          first_d = 1'b1;
        end
      end
      P2: begin
        if (expire) begin
          state_d = P3;
          load    = 1'b1;
          first_d = 1'b1;
        end
      end
      P3: begin
        if (expire) begin
          if (bounce_q && !tail_q) begin
            tail_d   = 1'b1;
            load     = 1'b1;
            load_val = DWELL_W'(BOUNCE_LEN - 2);
            first_d  = 1'b1;
          end else begin
            state_d = IDLE;
            tail_d  = 1'b0;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Second cycle of a bounced phase briefly shows the previous pattern again.
  always_comb begin
    ab_d = tail_d ? 2'b00 : phase_pat(state_d, dir_d);
    if (bounce_q && first_q) begin
      ab_d = tail_q ? phase_pat(P3, dir_q) : phase_pat(prev_state(state_q), dir_q);
    end
    busy_d = (state_d != IDLE);
    done_d = finish;
    cnt_d  = cnt_q + CNT_W'(finish);
  end

  assign bus.a        = ab_q[1];
  assign bus.b        = ab_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass_cnt = cnt_q;

endmodule

// File: tb/tb_car_sensor_gen.sv
// Bench for car_sensor_gen: directed passages plus random ones, scored every cycle
// against a queue of expected outputs expanded from each accepted passage.
module tb_car_sensor_gen;

  localparam int DWELL_W = 16;
  localparam int CNT_W   = 8;
  localparam int LAT_MAX = 400;

`ifdef CAR_SENSOR_GEN_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] ab;
    logic       done;
    logic       busy;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] m_cnt;
  logic [1:0]       prev_ab;

  car_sensor_gen_if #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) bus ();

  car_sensor_gen #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hold_n(input logic [DWELL_W-1:0] dw);
    return (dw == '0) ? 1 : int'(dw);
  endfunction

  function automatic int exp_lat(input logic [DWELL_W-1:0] dw);
    int n;
    n = hold_n(dw);
    return 3 * n + ((BOUNCE && n >= 4) ? 2 : 0);
  endfunction

  // Expected outputs after each edge of one passage, starting with the acceptance edge.
  function automatic void push_passage(input logic d, input logic [DWELL_W-1:0] dw);
    logic [1:0] pat[4];
    int         n;
    bit         bnc;
    exp_t       e;
    n      = hold_n(dw);
    bnc    = BOUNCE && (n >= 4);
    pat[0] = 2'b00;
    pat[1] = d ? 2'b01 : 2'b10;
    pat[2] = 2'b11;
    pat[3] = d ? 2'b10 : 2'b01;
    e.done = 1'b0;
    e.busy = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      for (int i = 0; i < n; i++) begin
        e.ab = (bnc && i == 1) ? pat[p-1] : pat[p];
        exp_q.push_back(e);
      end
    end
    if (bnc) begin
      e.ab = 2'b00;
      exp_q.push_back(e);
      e.ab = pat[3];
      exp_q.push_back(e);
    end
    e.ab   = 2'b00;
    e.done = 1'b1;
    e.busy = 1'b0;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      m_cnt   = '0;
      prev_ab = 2'b00;
    end else begin
      if (exp_q.size() == 0 && bus.start) push_passage(bus.dir, bus.dwell);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
      end else begin
        e.ab   = 2'b00;
        e.done = 1'b0;
        e.busy = 1'b0;
      end
      if (e.done) m_cnt = m_cnt + CNT_W'(1);
      #1;
      if (!reset) begin
        check("ab", {30'd0, bus.a, bus.b}, {30'd0, e.ab});
        check("done", {31'd0, bus.done}, {31'd0, e.done});
        check("busy", {31'd0, bus.busy}, {31'd0, e.busy});
        check("pass_cnt", {24'd0, bus.pass_cnt}, {24'd0, m_cnt});
        check("ab_single_step", {31'd0, (({bus.a, bus.b} ^ prev_ab) == 2'b11)}, 32'd0);
        prev_ab = {bus.a, bus.b};
      end
    end
  end

  task automatic run_passage(input logic d, input logic [DWELL_W-1:0] dw, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = d;
    bus.dwell = dw;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dir   = ~d;
    bus.dwell = DWELL_W'($urandom);
    lat = 0;
    while (!bus.done && lat < LAT_MAX) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int               lat;
    int               ndone;
    int               k;
    logic [CNT_W-1:0] cnt0;
    logic [DWELL_W-1:0] dw;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.dwell = '0;
    repeat (3) @(negedge clk);
    check("rst_ab", {30'd0, bus.a, bus.b}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_cnt", {24'd0, bus.pass_cnt}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Enter with N=2, then exit with dwell=0 (N=1).
    run_passage(1'b0, 16'd2, lat);
    check("lat_enter_n2", lat, 6);
    check("cnt_first", {24'd0, bus.pass_cnt}, 32'd1);
    run_passage(1'b1, 16'd0, lat);
    check("lat_exit_n1", lat, 3);

    // Starts during a dwell=3 passage are ignored.
    cnt0 = bus.pass_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.dwell = 16'd3;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = (i == 0 || i == 2);
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    check("ignored_start_dones", ndone, 1);
    check("ignored_start_cnt", {24'd0, bus.pass_cnt}, {24'd0, cnt0 + CNT_W'(1)});

    // 256 back-to-back passages with start held high; counter wraps back.
    cnt0 = bus.pass_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.dwell = 16'd1;
    ndone = 0;
    for (int i = 0; i < 256 * 4; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    check("b2b_last_done", {31'd0, bus.done}, 32'd1);
    check("b2b_dones", ndone, 256);
    check("b2b_wrap_cnt", {24'd0, bus.pass_cnt}, {24'd0, cnt0});

    // Asynchronous reset in the middle of P2.
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 1'b1;
    bus.dwell = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!(bus.a && bus.b) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reach_p2", {30'd0, bus.a, bus.b}, 32'd3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ab", {30'd0, bus.a, bus.b}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_cnt", {24'd0, bus.pass_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_passage(1'b1, 16'd5, lat);
    check("lat_after_rst", lat, exp_lat(16'd5));
    check("cnt_after_rst", {24'd0, bus.pass_cnt}, 32'd1);

    // Bounce-sized hold (bounce only with the macro defined).
    run_passage(1'b0, 16'd4, lat);
    check("lat_n4", lat, exp_lat(16'd4));

    // Random passages with random gaps.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      dw = DWELL_W'($urandom_range(0, 6));
      run_passage(1'($urandom_range(0, 1)), dw, lat);
      check("lat_rand", lat, exp_lat(dw));
    end

    repeat (4) @(negedge clk);
    check("final_idle_busy", {31'd0, bus.busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
